// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the byte-lane data memory.
// Requester 0 (core) has fixed priority. Requester 1 (loader/debug) gets an
// aging counter that forces a grant after a bounded wait. Grants are
// combinational. Read responses return one cycle later to the requester
// that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester 0: core execute-stage load/store port
  input  logic                m0_req_i,
  input  logic [DATA_W/8-1:0] m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wr_data_i,
  output logic                m0_gnt_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rd_data_o,
  // requester 1: loader/debug port
  input  logic                m1_req_i,
  input  logic [DATA_W/8-1:0] m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wr_data_i,
  output logic                m1_gnt_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rd_data_o,
  // shared memory port (synchronous read, data valid one cycle after address)
  output logic [DATA_W/8-1:0] mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wr_data_o,
  input  logic [DATA_W-1:0]   mem_rd_data_i
);

  localparam int         NB    = DATA_W / 8;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend0_q, rd_pend0_d;
  logic       rd_pend1_q, rd_pend1_d;
  logic       gnt0, gnt1;
  logic       starved;

  // Arbitration: core wins unless requester 1 has waited the full limit.
  always_comb begin
    starved = (wait_cnt_q >= LIMIT);
    gnt1    = m1_req_i && (!m0_req_i || starved);
    gnt0    = m0_req_i && !gnt1;
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Memory mux, built per byte lane; lanes pass through untouched and are
  // driven to zero when nobody is granted.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign mem_we_o[gi] = gnt0 ? m0_we_i[gi] :
                            gnt1 ? m1_we_i[gi] : 1'b0;
      assign mem_wr_data_o[gi*8 +: 8] = gnt0 ? m0_wr_data_i[gi*8 +: 8] :
                                        gnt1 ? m1_wr_data_i[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign mem_addr_o = gnt0 ? m0_addr_i :
                      gnt1 ? m1_addr_i : '0;

  // Next state: aging counter for requester 1 and pending-read flags.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rd_pend0_d = 1'b0;
    rd_pend1_d = 1'b0;
    if (!m1_req_i || gnt1) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    rd_pend0_d = gnt0 && (m0_we_i == '0);
    rd_pend1_d = gnt1 && (m1_we_i == '0);
  end

  // State registers; reset drops any in-flight read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
      rd_pend0_q <= 1'b0;
      rd_pend1_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend0_q <= rd_pend0_d;
      rd_pend1_q <= rd_pend1_d;
    end
  end

  // Route read data only to the requester owning the response.
  assign m0_rvalid_o  = rd_pend0_q;
  assign m1_rvalid_o  = rd_pend1_q;
  assign m0_rd_data_o = rd_pend0_q ? mem_rd_data_i : '0;
  assign m1_rd_data_o = rd_pend1_q ? mem_rd_data_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              m0_req, m1_req;
  logic [NB-1:0]     m0_we, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data, mem_rd_data;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wr_data_i(m0_wr_data),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rd_data_o(m0_rd_data),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wr_data_i(m1_wr_data),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rd_data_o(m1_rd_data),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data),
    .mem_rd_data_i(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_we = '0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_we = '0; m1_addr = '0; m1_wr_data = '0;
  endtask

  // Conflict pattern: core granted 4 cycles, loader forced on 5th, core on 6th.
  logic [5:0] exp_m0g = 6'b101111; // bit c-1 = expected m0_gnt in cycle c
  logic [3:0] exp_wc_seq [0:5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

  initial begin
    idle_all();
    mem_rd_data = '0;
    rst_n = 0;

    // Reset state
    settle();
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rd_data", m0_rd_data, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wait_cnt", dut.wait_cnt_q, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // Core-only read of 0x10
    m0_req = 1; m0_we = 4'b0000; m0_addr = 32'h10;
    settle();
    chk("core_rd_gnt", m0_gnt, 1);
    chk("core_rd_m1_gnt", m1_gnt, 0);
    chk("core_rd_mem_addr", mem_addr, 32'h10);
    chk("core_rd_mem_we", mem_we, 0);
    tick();
    idle_all();
    mem_rd_data = 32'hDEADBEEF;
    settle();
    chk("core_rd_rvalid", m0_rvalid, 1);
    chk("core_rd_data", m0_rd_data, 32'hDEADBEEF);
    chk("core_rd_m1_rvalid", m1_rvalid, 0);
    chk("core_rd_m1_data", m1_rd_data, 0);
    tick();
    chk("core_rd_rvalid_off", m0_rvalid, 0);
    chk("core_rd_data_off", m0_rd_data, 0);

    // Conflict: both request reads every cycle
    m0_req = 1; m0_addr = 32'h100;
    m1_req = 1; m1_addr = 32'h200;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk($sformatf("conf_c%0d_wait", c), dut.wait_cnt_q, exp_wc_seq[c-1]);
      chk($sformatf("conf_c%0d_m0_gnt", c), m0_gnt, exp_m0g[c-1]);
      chk($sformatf("conf_c%0d_m1_gnt", c), m1_gnt, !exp_m0g[c-1]);
      chk($sformatf("conf_c%0d_addr", c), mem_addr, exp_m0g[c-1] ? 32'h100 : 32'h200);
      if (c > 1) begin
        chk($sformatf("conf_c%0d_m0_rv", c), m0_rvalid, exp_m0g[c-2]);
        chk($sformatf("conf_c%0d_m1_rv", c), m1_rvalid, !exp_m0g[c-2]);
      end
      tick();
    end
    idle_all();
    tick();

    // Loader partial-lane write alone
    m1_req = 1; m1_we = 4'b0100; m1_addr = 32'h22; m1_wr_data = 32'h00AB0000;
    settle();
    chk("ldw_m1_gnt", m1_gnt, 1);
    chk("ldw_m0_gnt", m0_gnt, 0);
    chk("ldw_mem_we", mem_we, 4'b0100);
    chk("ldw_mem_addr", mem_addr, 32'h22);
    chk("ldw_mem_wdata", mem_wr_data, 32'h00AB0000);
    tick();
    idle_all();
    settle();
    chk("ldw_m0_rvalid", m0_rvalid, 0);
    chk("ldw_m1_rvalid", m1_rvalid, 0);
    chk("ldw_idle_mem_we", mem_we, 0);
    tick();

    // Interleaved reads: m0 at N, m1 at N+1
    m0_req = 1; m0_addr = 32'h30;
    settle();
    chk("il_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 0; m1_req = 1; m1_addr = 32'h40; mem_rd_data = 32'h11111111;
    settle();
    chk("il_m1_gnt", m1_gnt, 1);
    chk("il_n1_m0_rv", m0_rvalid, 1);
    chk("il_n1_m0_data", m0_rd_data, 32'h11111111);
    chk("il_n1_m1_rv", m1_rvalid, 0);
    chk("il_n1_m1_data", m1_rd_data, 0);
    tick();
    idle_all(); mem_rd_data = 32'h22222222;
    settle();
    chk("il_n2_m1_rv", m1_rvalid, 1);
    chk("il_n2_m1_data", m1_rd_data, 32'h22222222);
    chk("il_n2_m0_rv", m0_rvalid, 0);
    chk("il_n2_m0_data", m0_rd_data, 0);
    tick();

    // Loader drops req at wait_cnt=3, then reasserts
    m0_req = 1; m0_addr = 32'h50; m1_req = 1; m1_addr = 32'h60;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("drop_a%0d_m1_gnt", c), m1_gnt, 0);
      tick();
    end
    m1_req = 0;
    settle();
    chk("drop_wait3", dut.wait_cnt_q, 3);
    chk("drop_m1_gnt", m1_gnt, 0);
    chk("drop_m0_gnt", m0_gnt, 1);
    tick();
    m1_req = 1;
    for (int c = 1; c <= 5; c++) begin
      settle();
      chk($sformatf("drop_r%0d_m1_gnt", c), m1_gnt, (c == 5));
      chk($sformatf("drop_r%0d_m0_gnt", c), m0_gnt, (c != 5));
      tick();
    end
    idle_all();
    tick();

    // Reset pulsed the cycle after a granted read
    m0_req = 1; m0_addr = 32'h70;
    settle();
    chk("rr_gnt", m0_gnt, 1);
    tick();
    idle_all(); mem_rd_data = 32'h55555555;
    m1_req = 1; m1_addr = 32'h80; // builds wait_cnt? no: m0 idle so m1 granted
    rst_n = 0;
    settle();
    chk("rr_rvalid_now", m0_rvalid, 0);
    chk("rr_data_now", m0_rd_data, 0);
    chk("rr_wait_now", dut.wait_cnt_q, 0);
    m1_req = 0;
    tick();
    rst_n = 1;
    m0_req = 1; m0_addr = 32'h90; // read granted in the cycle reset releases
    settle();
    chk("rr_rvalid_rel", m0_rvalid, 0);
    chk("rr_m1_rvalid_rel", m1_rvalid, 0);
    chk("rr_wait_rel", dut.wait_cnt_q, 0);
    chk("rr_gnt_rel", m0_gnt, 1);
    tick();
    idle_all(); mem_rd_data = 32'hCAFEF00D;
    settle();
    chk("rr_post_rvalid", m0_rvalid, 1);
    chk("rr_post_data", m0_rd_data, 32'hCAFEF00D);
    tick();
    chk("rr_post_rvalid_off", m0_rvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the byte-lane data memory between the core's execute-stage load/store port (requester 0) and a loader/debug port (requester 1). Fixed priority to the core, with an aging counter that forces a grant to requester 1 after a bounded wait. Grants are combinational, so the core keeps single-cycle store timing. Read responses are routed back one cycle later to the requester that issued them.

## Interface
- ADDR_W, 32, address width on both requester ports and the memory port
- DATA_W, 32, data width; byte lanes = DATA_W/8, must be a multiple of 8
- STARVE_LIMIT, 4, cycles requester 1 may wait before forced grant; legal range 1..15
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- m0_req  input  1  core requests an access this cycle
- m0_we  input  DATA_W/8  byte write enables; all zero = read
- m0_addr  input  ADDR_W  byte address
- m0_wr_data  input  DATA_W  lane-aligned write data
- m0_gnt  output  1  core access accepted this cycle; 0 while m0_req=1 means core must stall
- m0_rvalid  output  1  read data for core valid
- m0_rd_data  output  DATA_W  read data, 0 when m0_rvalid=0
- m1_req, m1_we, m1_addr, m1_wr_data, m1_gnt, m1_rvalid, m1_rd_data: same as m0_* for requester 1
- mem_we  output  DATA_W/8  per-lane write enables to memory
- mem_addr  output  ADDR_W  address to memory
- mem_wr_data  output  DATA_W  write data to memory
- mem_rd_data  input  DATA_W  synchronous-read data, valid the cycle after address is presented

## Operation
- Arbitration, combinational each cycle:
  - only m0_req: grant m0
  - only m1_req: grant m1
  - both and wait_cnt < STARVE_LIMIT: grant m0
  - both and wait_cnt == STARVE_LIMIT: grant m1, m0_gnt=0
  - neither: no grant
- At most one gnt high per cycle. gnt never asserts without the matching req.
- Memory mux: the granted requester's we/addr/wr_data drive mem_*. With no grant, mem_we=0, mem_addr=0, mem_wr_data=0.
- wait_cnt (4 bits):
  - cleared when m1 is granted or m1_req=0
  - incremented when m1_req=1 and m1_gnt=0
  - saturates at STARVE_LIMIT
- Read tracking: registers rd_pend0 and rd_pend1 are set on the cycle after a granted access with we==0; otherwise cleared. mN_rvalid = rd_pendN.
- mN_rd_data = mem_rd_data when rd_pendN, else 0.
- Writes produce no rvalid. Partial-lane writes pass we unchanged; the arbiter does not merge or realign lanes.
- Back-to-back accesses from either requester, in any mix, are accepted every cycle without bubbles.

## Timing
- Reset (rst_n=0, asynchronous): wait_cnt=0, rd_pend0=rd_pend1=0, so rvalid=0 and rd_data=0. gnt and mem_* follow the combinational rules; with req low they are 0.
- Grant latency: 0 cycles (req to gnt in the same cycle). Read latency: 1 cycle (grant at cycle N, rvalid and rd_data at N+1).
- Worst-case wait for requester 1 under continuous core traffic: STARVE_LIMIT cycles, granted on cycle STARVE_LIMIT+1 of asserting req. After the forced grant, wait_cnt=0 and the core regains priority next cycle.
- Requester 1 must hold req/we/addr/wr_data stable until granted. The core is not required to hold them; it stalls on gnt=0.
- Reset asserted mid-read: the pending response is dropped and no rvalid is issued after reset release.
- A read granted in the same cycle that rst_n rises produces rvalid on the next cycle, as normal.

## Test plan
- Core only: m0 reads addr 0x10 (mem returns 0xDEADBEEF) -> m0_gnt=1 at N; m0_rvalid=1 with m0_rd_data=0xDEADBEEF at N+1; m1_rvalid stays 0.
- Conflict: both req every cycle, STARVE_LIMIT=4 -> m0 granted cycles 1-4, m1 granted cycle 5 with m0_gnt=0, m0 granted cycle 6.
- Loader write alone: m1_we=4'b0100, addr 0x22, data 0x00AB0000 -> mem_we=4'b0100, mem_addr=0x22 the same cycle; no rvalid on either port.
- Interleaved reads: m0 read at N, m1 read at N+1 (core idle) -> m0_rvalid at N+1 only, m1_rvalid at N+2 only, each carrying that cycle's mem_rd_data.
- m1 drops req at wait_cnt=3, then reasserts -> wait_cnt restarts from 0; forced grant occurs 4 cycles later, not earlier.
- rst_n pulsed low the cycle after a granted read -> m0_rvalid=0 immediately and stays 0 after release; wait_cnt reads 0.
